// File: rtl/info_packet_pkg.sv
// Shared definitions for the data-island slot-0 packet scheduler: state
// encoding and the packet header bytes the encoder pairs with each selection.
package info_packet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REGEN = 2'd1,
    ST_AVI   = 2'd2,
    ST_AINFO = 2'd3
  } state_t;

  localparam logic [23:0] HDR_ACR   = 24'h000001;
  localparam logic [23:0] HDR_AINFO = 24'h0A0184;
  localparam logic [23:0] HDR_AVI   = 24'h0D0282;

  // Header the encoder should load for a given selection (zero when idle).
  function automatic logic [23:0] header_of(state_t s);
    logic [23:0] hdr;
    hdr = 24'h000000;
    case (s)
      ST_REGEN: hdr = HDR_ACR;
      ST_AVI:   hdr = HDR_AVI;
      ST_AINFO: hdr = HDR_AINFO;
      default:  hdr = 24'h000000;
    endcase
    return hdr;
  endfunction

endpackage

// File: rtl/info_packet_state_if.sv
// Request/select bundle between the packet scheduler and the data-island
// encoder. The master side raises requests and reports transmission; the
// slave side (the scheduler) returns the one-hot packet selection.
interface info_packet_state_if;

  logic start_of_frame;
  logic audio_regen_needed;
  logic packet_sent;
  logic audio_regen;
  logic audio_info;
  logic video_info;
  logic packet_needed;

  modport master (
    output start_of_frame,
    output audio_regen_needed,
    output packet_sent,
    input  audio_regen,
    input  audio_info,
    input  video_info,
    input  packet_needed
  );

  modport slave (
    input  start_of_frame,
    input  audio_regen_needed,
    input  packet_sent,
    output audio_regen,
    output audio_info,
    output video_info,
    output packet_needed
  );

endinterface

// File: rtl/info_packet_state.sv
// Slot-0 packet scheduler for the HDMI data-island encoder.
// Latches ACR / AVI / audio-infoframe requests as sticky pending flags and
// selects one packet at a time, holding it until the encoder reports it sent.
// Build option: INFOPKT_AUDIO_INFO_EN enables audio infoframe scheduling;
// without it the audio infoframe is never requested and audio_info stays 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing selected; picks highest-priority pending next cycle
// ST_REGEN | ACR packet selected, waiting for packet_sent
// ST_AVI   | AVI infoframe selected, waiting for packet_sent
// ST_AINFO | audio infoframe selected, waiting for packet_sent
module info_packet_state
  import info_packet_pkg::*;
#(
  parameter int FRAMES_PER_INFO = 1
) (
  input  logic                i_pixclk,
  input  logic                i_reset,
  info_packet_state_if.slave  bus
);

  localparam int CW = (FRAMES_PER_INFO > 1) ? $clog2(FRAMES_PER_INFO) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMES_PER_INFO - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] frame_cnt_nxt;
  logic          info_req;

  logic          regen_pend;
  logic          regen_pend_nxt;
  logic          clr_regen;
  logic          avi_pend;
  logic          avi_pend_nxt;
  logic          clr_avi;
`ifdef INFOPKT_AUDIO_INFO_EN
  logic          ainfo_pend;
  logic          ainfo_pend_nxt;
  logic          clr_ainfo;
  logic          audio_info_q;
`endif

  logic          audio_regen_q;
  logic          video_info_q;
  logic          packet_needed_q;

  // Frame counter: infoframes are due on the frame where the count is zero.
  always_comb begin
    info_req      = bus.start_of_frame && (frame_cnt == '0);
    frame_cnt_nxt = frame_cnt;
    if (bus.start_of_frame) begin
      if (frame_cnt == CNT_MAX) begin
        frame_cnt_nxt = '0;
      end else begin
        frame_cnt_nxt = frame_cnt + CW'(1);
      end
    end
  end

  // Next state: priority pick out of IDLE, hold a selection until sent.
  always_comb begin
    state_nxt = state;
    clr_regen = 1'b0;
    clr_avi   = 1'b0;
`ifdef INFOPKT_AUDIO_INFO_EN
    clr_ainfo = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (regen_pend) begin
          state_nxt = ST_REGEN;
          clr_regen = 1'b1;
        end else if (avi_pend) begin
          state_nxt = ST_AVI;
          clr_avi   = 1'b1;
        end
`ifdef INFOPKT_AUDIO_INFO_EN
        else if (ainfo_pend) begin
          state_nxt = ST_AINFO;
          clr_ainfo = 1'b1;
        end
`endif
      end
      ST_REGEN, ST_AVI, ST_AINFO: begin
        if (bus.packet_sent) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending flags: a new request wins over a clear in the same cycle, and
  // repeated requests simply merge into the already-set flag.
  always_comb begin
    regen_pend_nxt = bus.audio_regen_needed | (regen_pend & ~clr_regen);
    avi_pend_nxt   = info_req | (avi_pend & ~clr_avi);
`ifdef INFOPKT_AUDIO_INFO_EN
    ainfo_pend_nxt = info_req | (ainfo_pend & ~clr_ainfo);
`endif
  end

  // State, pending flags and frame counter registers.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      regen_pend <= 1'b0;
      avi_pend   <= 1'b0;
`ifdef INFOPKT_AUDIO_INFO_EN
      ainfo_pend <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_cnt_nxt;
      regen_pend <= regen_pend_nxt;
      avi_pend   <= avi_pend_nxt;
`ifdef INFOPKT_AUDIO_INFO_EN
      ainfo_pend <= ainfo_pend_nxt;
`endif
    end
  end

  // Registered one-hot selects, decoded from the next state so they track
  // the state register exactly.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      audio_regen_q   <= 1'b0;
      video_info_q    <= 1'b0;
      packet_needed_q <= 1'b0;
`ifdef INFOPKT_AUDIO_INFO_EN
      audio_info_q    <= 1'b0;
`endif
    end else begin
      audio_regen_q   <= (state_nxt == ST_REGEN);
      video_info_q    <= (state_nxt == ST_AVI);
      packet_needed_q <= (state_nxt != ST_IDLE);
`ifdef INFOPKT_AUDIO_INFO_EN
      audio_info_q    <= (state_nxt == ST_AINFO);
`endif
    end
  end

  assign bus.audio_regen   = audio_regen_q;
  assign bus.video_info    = video_info_q;
  assign bus.packet_needed = packet_needed_q;
`ifdef INFOPKT_AUDIO_INFO_EN
  assign bus.audio_info    = audio_info_q;
`else
  assign bus.audio_info    = 1'b0;
`endif

endmodule

// File: tb/tb_info_packet_state.sv
// Directed bench for the slot-0 packet scheduler. Expected selections are
// queued as requests are driven and popped as the scheduler presents them.
// dut_a runs with one infoframe per frame, dut_b with one every third frame.
module tb_info_packet_state;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_ACR  = 3'b100;
  localparam logic [2:0] SEL_AVI  = 3'b010;
  localparam logic [2:0] SEL_AI   = 3'b001;
`ifdef INFOPKT_AUDIO_INFO_EN
  localparam bit AI_EN = 1'b1;
`else
  localparam bit AI_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  info_packet_state_if ifa ();
  info_packet_state_if ifb ();

  info_packet_state #(.FRAMES_PER_INFO(1)) dut_a (
    .i_pixclk (clk),
    .i_reset  (rst),
    .bus      (ifa)
  );

  info_packet_state #(.FRAMES_PER_INFO(3)) dut_b (
    .i_pixclk (clk),
    .i_reset  (rst),
    .bus      (ifb)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [2:0] sb[$];
  bit         ai_seen  = 1'b0;

  always @(negedge clk) begin
    if (ifa.audio_info === 1'b1 || ifb.audio_info === 1'b1) ai_seen = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] sel_of(bit b);
    if (b) return {ifb.audio_regen, ifb.video_info, ifb.audio_info};
    return {ifa.audio_regen, ifa.video_info, ifa.audio_info};
  endfunction

  function automatic logic need_of(bit b);
    if (b) return ifb.packet_needed;
    return ifa.packet_needed;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag, bit b);
    chk(tag, sel_of(b), SEL_NONE);
    chk({tag, "_need"}, {2'b00, need_of(b)}, 3'b000);
  endtask

  task automatic expect_now(string tag, bit b);
    logic [2:0] exp;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, sel_of(b), exp);
      chk({tag, "_need"}, {2'b00, need_of(b)}, {2'b00, |exp});
    end
  endtask

  task automatic expect_or_idle(string tag, bit b);
    if (sb.size() != 0) expect_now(tag, b);
    else chk_idle(tag, b);
  endtask

  task automatic pulse(bit b, bit sof, bit rgn);
    if (b) begin
      ifb.start_of_frame = sof;
      ifb.audio_regen_needed = rgn;
    end else begin
      ifa.start_of_frame = sof;
      ifa.audio_regen_needed = rgn;
    end
    step();
    ifa.start_of_frame = 1'b0;
    ifa.audio_regen_needed = 1'b0;
    ifb.start_of_frame = 1'b0;
    ifb.audio_regen_needed = 1'b0;
  endtask

  task automatic send(string tag, bit b);
    if (b) ifb.packet_sent = 1'b1;
    else ifa.packet_sent = 1'b1;
    step();
    ifa.packet_sent = 1'b0;
    ifb.packet_sent = 1'b0;
    chk_idle({tag, "_gap"}, b);
    step();
  endtask

  initial begin
    ifa.start_of_frame = 1'b0; ifa.audio_regen_needed = 1'b0; ifa.packet_sent = 1'b0;
    ifb.start_of_frame = 1'b0; ifb.audio_regen_needed = 1'b0; ifb.packet_sent = 1'b0;

    // 1: reset for 3 cycles, then 100 quiet cycles
    rst = 1'b1;
    repeat (3) step();
    chk_idle("t1_in_reset", 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      chk_idle("t1_quiet_a", 0);
      chk_idle("t1_quiet_b", 1);
    end

    // 2: frame start -> AVI at +2, then audio infoframe after one gap cycle
    sb.push_back(SEL_AVI);
    if (AI_EN) sb.push_back(SEL_AI);
    pulse(0, 1, 0);
    chk_idle("t2_lat1", 0);
    step();
    expect_now("t2_avi", 0);
    repeat (3) begin
      step();
      chk("t2_hold", sel_of(0), SEL_AVI);
    end
    send("t2_avi", 0);
    expect_or_idle("t2_ai", 0);
    send("t2_ai", 0);
    repeat (3) begin
      chk_idle("t2_done", 0);
      step();
    end

    // 3: simultaneous frame start and ACR request -> ACR, AVI, audio info
    sb.push_back(SEL_ACR);
    sb.push_back(SEL_AVI);
    if (AI_EN) sb.push_back(SEL_AI);
    pulse(0, 1, 1);
    step();
    expect_now("t3_acr", 0);
    repeat (2) begin
      step();
      chk("t3_hold_acr", sel_of(0), SEL_ACR);
    end
    send("t3_acr", 0);
    expect_now("t3_avi", 0);
    send("t3_avi", 0);
    expect_or_idle("t3_ai", 0);
    send("t3_ai", 0);
    chk_idle("t3_done", 0);

    // 4: three ACR requests during AVI merge into a single ACR selection
    sb.push_back(SEL_AVI);
    pulse(0, 1, 0);
    step();
    expect_now("t4_avi", 0);
    sb.push_back(SEL_ACR);
    if (AI_EN) sb.push_back(SEL_AI);
    for (int i = 0; i < 3; i++) begin
      pulse(0, 0, 1);
      chk("t4_hold_avi", sel_of(0), SEL_AVI);
      step();
    end
    send("t4_avi", 0);
    expect_now("t4_acr", 0);
    send("t4_acr", 0);
    expect_or_idle("t4_ai", 0);
    send("t4_ai", 0);
    for (int i = 0; i < 10; i++) begin
      chk_idle("t4_single_acr", 0);
      step();
    end

    // 5: every third frame carries infoframes on dut_b
    for (int f = 0; f < 6; f++) begin
      if (f % 3 == 0) begin
        sb.push_back(SEL_AVI);
        if (AI_EN) sb.push_back(SEL_AI);
      end
      pulse(1, 1, 0);
      step();
      if (f % 3 == 0) begin
        expect_now("t5_avi", 1);
        send("t5_avi", 1);
        expect_or_idle("t5_ai", 1);
        send("t5_ai", 1);
      end else begin
        repeat (4) begin
          chk_idle("t5_skip_frame", 1);
          step();
        end
      end
    end

    // 6: reset while ACR selected and AVI pending drops everything
    sb.push_back(SEL_ACR);
    pulse(0, 1, 1);
    step();
    expect_now("t6_acr", 0);
    rst = 1'b1;
    step();
    chk_idle("t6_reset", 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle("t6_after_reset", 0);
    end

    chk("sb_empty", {2'b00, sb.size() == 0}, 3'b001);
    chk("ai_seen", {2'b00, ai_seen}, {2'b00, AI_EN});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
